// File: rtl/segment_if_id_pkg.sv
// Shared pipeline constants: register widths and the bit positions of every
// instruction field the decode stage picks out of the IF/ID instruction word.
package segment_if_id_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  // High/low bit of each decoder-alternative slice of the instruction register
  localparam int unsigned INSTR_31_30_HI = 31;
  localparam int unsigned INSTR_31_30_LO = 30;
  localparam int unsigned INSTR_29_25_HI = 29;
  localparam int unsigned INSTR_29_25_LO = 25;
  localparam int unsigned INSTR_27_24_HI = 27;
  localparam int unsigned INSTR_27_24_LO = 24;
  localparam int unsigned INSTR_21_18_HI = 21;
  localparam int unsigned INSTR_21_18_LO = 18;
  localparam int unsigned INSTR_20_17_HI = 20;
  localparam int unsigned INSTR_20_17_LO = 17;
  localparam int unsigned INSTR_7_4_HI   = 7;
  localparam int unsigned INSTR_7_4_LO   = 4;
  localparam int unsigned INSTR_23_20_HI = 23;
  localparam int unsigned INSTR_23_20_LO = 20;
  localparam int unsigned INSTR_16_13_HI = 16;
  localparam int unsigned INSTR_16_13_LO = 13;
  localparam int unsigned INSTR_25_22_HI = 25;
  localparam int unsigned INSTR_25_22_LO = 22;
  localparam int unsigned INSTR_24_21_HI = 24;
  localparam int unsigned INSTR_24_21_LO = 21;
  localparam int unsigned INSTR_11_8_HI  = 11;
  localparam int unsigned INSTR_11_8_LO  = 8;
  localparam int unsigned INSTR_27_0_HI  = 27;
  localparam int unsigned INSTR_27_0_LO  = 0;

endpackage

// File: rtl/segment_if_id_if.sv
// IF/ID bus bundle: fetch side drives PC and instruction, decode side receives
// the registered PC and the instruction field slices.
interface segment_if_id_if;
  import segment_if_id_pkg::*;

  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    pc;
  logic [1:0]         instr_31_30;
  logic [4:0]         instr_29_25;
  logic [3:0]         instr_27_24;
  logic [3:0]         instr_21_18;
  logic [3:0]         instr_20_17;
  logic [3:0]         instr_7_4;
  logic [3:0]         instr_23_20;
  logic [3:0]         instr_16_13;
  logic [3:0]         instr_25_22;
  logic [3:0]         instr_24_21;
  logic [3:0]         instr_11_8;
  logic [27:0]        instr_27_0;

  modport master (
    output pc_out, instruction,
    input  pc, instr_31_30, instr_29_25, instr_27_24, instr_21_18, instr_20_17,
           instr_7_4, instr_23_20, instr_16_13, instr_25_22, instr_24_21,
           instr_11_8, instr_27_0
  );

  modport slave (
    input  pc_out, instruction,
    output pc, instr_31_30, instr_29_25, instr_27_24, instr_21_18, instr_20_17,
           instr_7_4, instr_23_20, instr_16_13, instr_25_22, instr_24_21,
           instr_11_8, instr_27_0
  );

endinterface

// File: rtl/segment_if_id_pipe_reg.sv
// Generic pipeline register: parameterised width and reset value, rising-edge
// clock, asynchronous active-high reset.
module pipe_reg #(
  parameter int unsigned           WIDTH     = 32,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  assign data_d = d_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/segment_if_id.sv
// IF/ID pipeline segment: registers the fetched PC and instruction and exposes
// fixed field slices of the single instruction register to the decode stage.
module segment_if_id
  import segment_if_id_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC    = 32'h0,
  parameter logic [INSTR_W-1:0] RESET_INSTR = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_out,
  input  logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic [1:0]         instr_31_30,
  output logic [4:0]         instr_29_25,
  output logic [3:0]         instr_27_24,
  output logic [3:0]         instr_21_18,
  output logic [3:0]         instr_20_17,
  output logic [3:0]         instr_7_4,
  output logic [3:0]         instr_23_20,
  output logic [3:0]         instr_16_13,
  output logic [3:0]         instr_25_22,
  output logic [3:0]         instr_24_21,
  output logic [3:0]         instr_11_8,
  output logic [27:0]        instr_27_0
);

  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;

  pipe_reg #(
    .WIDTH     (PC_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .d_i (pc_out),
    .q_o (pc_q)
  );

  pipe_reg #(
    .WIDTH     (INSTR_W),
    .RESET_VAL (RESET_INSTR)
  ) u_instr_reg (
    .clk (clk),
    .rst (rst),
    .d_i (instruction),
    .q_o (instr_q)
  );

  assign pc = pc_q;

  // All fields come from one register, so overlapping slices never disagree
  assign instr_31_30 = instr_q[INSTR_31_30_HI:INSTR_31_30_LO];
  assign instr_29_25 = instr_q[INSTR_29_25_HI:INSTR_29_25_LO];
  assign instr_27_24 = instr_q[INSTR_27_24_HI:INSTR_27_24_LO];
  assign instr_21_18 = instr_q[INSTR_21_18_HI:INSTR_21_18_LO];
  assign instr_20_17 = instr_q[INSTR_20_17_HI:INSTR_20_17_LO];
  assign instr_7_4   = instr_q[INSTR_7_4_HI:INSTR_7_4_LO];
  assign instr_23_20 = instr_q[INSTR_23_20_HI:INSTR_23_20_LO];
  assign instr_16_13 = instr_q[INSTR_16_13_HI:INSTR_16_13_LO];
  assign instr_25_22 = instr_q[INSTR_25_22_HI:INSTR_25_22_LO];
  assign instr_24_21 = instr_q[INSTR_24_21_HI:INSTR_24_21_LO];
  assign instr_11_8  = instr_q[INSTR_11_8_HI:INSTR_11_8_LO];
  assign instr_27_0  = instr_q[INSTR_27_0_HI:INSTR_27_0_LO];

endmodule

// File: tb/tb_segment_if_id.sv
// Self-checking bench for segment_if_id: random captures checked by a queue
// scoreboard, plus directed reset, hold and field-extraction scenarios.
module tb_segment_if_id;

  localparam logic [31:0] RESET_PC    = 32'h0;
  localparam logic [31:0] RESET_INSTR = 32'h0;

  logic clk;
  logic rst;
  logic sbOn;
  int   vectorCount;
  int   failCount;
  logic [63:0] expQ[$];

  segment_if_id_if bus ();

  segment_if_id dut (
    .clk         (clk),
    .rst         (rst),
    .pc_out      (bus.pc_out),
    .instruction (bus.instruction),
    .pc          (bus.pc),
    .instr_31_30 (bus.instr_31_30),
    .instr_29_25 (bus.instr_29_25),
    .instr_27_24 (bus.instr_27_24),
    .instr_21_18 (bus.instr_21_18),
    .instr_20_17 (bus.instr_20_17),
    .instr_7_4   (bus.instr_7_4),
    .instr_23_20 (bus.instr_23_20),
    .instr_16_13 (bus.instr_16_13),
    .instr_25_22 (bus.instr_25_22),
    .instr_24_21 (bus.instr_24_21),
    .instr_11_8  (bus.instr_11_8),
    .instr_27_0  (bus.instr_27_0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Field value from the instruction word, by plain shift and mask
  function automatic logic [31:0] fieldOf(input logic [31:0] w, input int hi, input int lo);
    logic [31:0] mask;
    mask = (32'h1 << (hi - lo + 1)) - 32'h1;
    return (w >> lo) & mask;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    vectorCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expPc, input logic [31:0] expInstr);
    cmp({tag, ".pc"},          bus.pc,                expPc);
    cmp({tag, ".instr_31_30"}, 32'(bus.instr_31_30), fieldOf(expInstr, 31, 30));
    cmp({tag, ".instr_29_25"}, 32'(bus.instr_29_25), fieldOf(expInstr, 29, 25));
    cmp({tag, ".instr_27_24"}, 32'(bus.instr_27_24), fieldOf(expInstr, 27, 24));
    cmp({tag, ".instr_21_18"}, 32'(bus.instr_21_18), fieldOf(expInstr, 21, 18));
    cmp({tag, ".instr_20_17"}, 32'(bus.instr_20_17), fieldOf(expInstr, 20, 17));
    cmp({tag, ".instr_7_4"},   32'(bus.instr_7_4),   fieldOf(expInstr, 7, 4));
    cmp({tag, ".instr_23_20"}, 32'(bus.instr_23_20), fieldOf(expInstr, 23, 20));
    cmp({tag, ".instr_16_13"}, 32'(bus.instr_16_13), fieldOf(expInstr, 16, 13));
    cmp({tag, ".instr_25_22"}, 32'(bus.instr_25_22), fieldOf(expInstr, 25, 22));
    cmp({tag, ".instr_24_21"}, 32'(bus.instr_24_21), fieldOf(expInstr, 24, 21));
    cmp({tag, ".instr_11_8"},  32'(bus.instr_11_8),  fieldOf(expInstr, 11, 8));
    cmp({tag, ".instr_27_0"},  32'(bus.instr_27_0),  fieldOf(expInstr, 27, 0));
  endtask

  // Drive new inputs just after a falling edge, away from the capture edge
  task automatic applyStimulus(input logic [31:0] pcVal, input logic [31:0] instrVal);
    @(negedge clk);
    #2;
    bus.pc_out      = pcVal;
    bus.instruction = instrVal;
  endtask

  // Reference model: each rising edge yields the inputs, or reset values if rst is high
  always @(posedge clk) begin
    if (sbOn) begin
      #1;
      if (rst) expQ.push_back({RESET_PC, RESET_INSTR});
      else     expQ.push_back({bus.pc_out, bus.instruction});
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("sb", e[63:32], e[31:0]);
    end
  end

  initial begin
    logic [31:0] holdPc;
    logic [31:0] holdInstr;
    vectorCount     = 0;
    failCount       = 0;
    sbOn            = 1'b0;
    rst             = 1'b0;
    bus.pc_out      = 32'h1;
    bus.instruction = 32'hAFAFAFAF;

    // Reset from unknown, no clock edge involved
    #2 rst = 1'b1;
    #1 checkOutput("rst_async", RESET_PC, RESET_INSTR);
    #1 rst = 1'b0;
    sbOn = 1'b1;
    #0.5 checkOutput("rst_release", RESET_PC, RESET_INSTR);

    // Field extraction on first edge, with literal expected values
    @(posedge clk);
    #1;
    cmp("fx.pc",          bus.pc,                32'h1);
    cmp("fx.instr_31_30", 32'(bus.instr_31_30), 32'h2);
    cmp("fx.instr_29_25", 32'(bus.instr_29_25), 32'h17);
    cmp("fx.instr_27_24", 32'(bus.instr_27_24), 32'hF);
    cmp("fx.instr_21_18", 32'(bus.instr_21_18), 32'hB);
    cmp("fx.instr_20_17", 32'(bus.instr_20_17), 32'h7);
    cmp("fx.instr_7_4",   32'(bus.instr_7_4),   32'hA);
    cmp("fx.instr_23_20", 32'(bus.instr_23_20), 32'hA);
    cmp("fx.instr_16_13", 32'(bus.instr_16_13), 32'hD);
    cmp("fx.instr_25_22", 32'(bus.instr_25_22), 32'hE);
    cmp("fx.instr_24_21", 32'(bus.instr_24_21), 32'hD);
    cmp("fx.instr_11_8",  32'(bus.instr_11_8),  32'hF);
    cmp("fx.instr_27_0",  32'(bus.instr_27_0),  32'hFAFAFAF);

    // Inputs changing between edges must not reach the outputs
    #1;
    bus.pc_out      = 32'h12345678;
    bus.instruction = 32'h5A5AC3C3;
    #1 checkOutput("hold", 32'h1, 32'hAFAFAFAF);

    // Back-to-back capture of all-zero inputs
    applyStimulus(32'h0, 32'h0);
    @(posedge clk);
    #1 checkOutput("zero", 32'h0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom, $urandom);
    end

    // Asynchronous reset mid-operation, held across clock toggles
    applyStimulus(32'hCAFE0004, 32'hAFAFAFAF);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("rst_mid", RESET_PC, RESET_INSTR);
    repeat (3) @(posedge clk);
    #2 checkOutput("rst_held", RESET_PC, RESET_INSTR);
    @(negedge clk);
    #2 rst = 1'b0;
    bus.pc_out      = $urandom;
    bus.instruction = $urandom;
    #1 checkOutput("rst_fall", RESET_PC, RESET_INSTR);

    // Reset asserted in the same timestep as a rising edge
    applyStimulus(32'hDEADBEE0, 32'hFFFFFFFF);
    @(posedge clk);
    rst = 1'b1;
    #1 checkOutput("race", RESET_PC, RESET_INSTR);
    @(negedge clk);
    #2 rst = 1'b0;
    holdPc    = bus.pc_out;
    holdInstr = bus.instruction;
    @(posedge clk);
    #1 checkOutput("race_after", holdPc, holdInstr);

    for (int i = 0; i < 20; i++) begin
      applyStimulus($urandom, $urandom);
    end

    sbOn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    cmp("sb_drained", 32'(expQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule

// File: doc/segment_if_id.md
SEGMENT_IF_ID -- requirements
Module: segment_if_id

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter RESET_PC SHALL default to 32'h0 and give the value of pc while reset is active and after it.
REQ-003 Parameter RESET_INSTR SHALL default to 32'h0 and give the stored instruction value while reset is active and after it.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port pc_out, input, 32 bits: PC value from the fetch stage.
REQ-007 Port instruction, input, 32 bits: fetched instruction word.
REQ-008 Port pc, output, 32 bits: registered PC for the decode stage.
REQ-009 Port instr_31_30, output, 2 bits: registered instruction[31:30].
REQ-010 Port instr_29_25, output, 5 bits: registered instruction[29:25].
REQ-011 Ports instr_27_24, instr_21_18, instr_20_17, instr_7_4, instr_23_20, instr_16_13, instr_25_22, instr_24_21 and instr_11_8 SHALL be outputs, 4 bits each, each equal to the registered instruction bits named in the port.
REQ-012 Port instr_27_0, output, 28 bits: registered instruction[27:0].
REQ-013 The port order SHALL be exactly as listed in REQ-004 to REQ-012, because instantiation is positional.

Function
REQ-014 On each rising edge of clk with rst low, the block SHALL capture pc_out into the PC register and instruction into the instruction register.
REQ-015 Latency from input to output SHALL be exactly one clock edge; there is no combinational path from input to output.
REQ-016 The block SHALL have no stall, flush or enable; it captures on every edge.
REQ-017 Every instr_* output SHALL be a combinational slice of the single 32-bit instruction register.
REQ-018 Overlapping field slices SHALL always be mutually consistent, including the same cycle after reset.
REQ-019 The instr_* fields are decoder alternatives: all of them SHALL be driven in every cycle regardless of opcode.
REQ-020 The block SHALL perform no decoding, sign-extension or arithmetic.
REQ-021 If input values contain X or Z, the block SHALL propagate them unchanged; there is no X-masking.

Reset
REQ-022 When rst rises, pc SHALL go to RESET_PC immediately, without waiting for a clock edge.
REQ-023 When rst rises, the instruction register SHALL go to RESET_INSTR immediately, so every instr_* output reads 0 by default.
REQ-024 While rst is high, clock edges SHALL be ignored.
REQ-025 Reset SHALL take priority over a clock edge that occurs in the same timestep.
REQ-026 After rst falls, the first rising edge of clk SHALL capture the inputs normally.
REQ-027 A reset that arrives mid-operation SHALL discard the held instruction and PC; there is no recovery of state.

Structure
REQ-028 The bit positions of the fields (high and low bit of each slice) SHALL be defined as constants in a shared pipeline package, so decode logic reuses them.
REQ-029 A generic sub-module pipe_reg SHALL hold the registers: parameterised width and reset value, asynchronous reset, rising-edge clock.
REQ-030 pipe_reg SHALL be instantiated twice, once for the PC and once for the instruction.

Verification
REQ-031 Scenario (reset from unknown): pulse rst high, then low, before any capture -> pc = 0 and all instr_* outputs = 0 immediately, with no clock edge needed.
REQ-032 Scenario (field extraction): pc_out = 1 and instruction = 32'hAFAFAFAF, then one rising edge -> pc = 1 and the fields read:
- instr_31_30 = 2'b10
- instr_29_25 = 5'h17
- instr_27_24 = 4'hF
- instr_21_18 = 4'hB
- instr_20_17 = 4'h7
- instr_7_4 = 4'hA
- instr_23_20 = 4'hA
- instr_16_13 = 4'hD
- instr_25_22 = 4'hE
- instr_24_21 = 4'hD
- instr_11_8 = 4'hF
- instr_27_0 = 28'hFAFAFAF
REQ-033 Scenario (no premature capture): change the inputs between edges -> the outputs hold their previous values until the next rising edge.
REQ-034 Scenario (back-to-back capture): after the REQ-032 scenario, drive pc_out = 0 and instruction = 0, then one edge -> pc = 0 and all fields = 0.
REQ-035 Scenario (asynchronous reset mid-operation): with 32'hAFAFAFAF held, raise rst between clock edges -> all outputs = 0 at once and stay 0 while rst is high, despite clock toggles.
REQ-036 Scenario (reset/clock race): assert rst at a rising edge while the inputs are nonzero -> the outputs are 0; after rst is released, the next edge captures the inputs.
